// File: rtl/du_program_sequencer.sv
// du_program_sequencer
//   Debug-unit-side sequencer for the pipeline debug port. It loads a program
//   word by word into instruction memory at consecutive word addresses. It then
//   runs the pipeline until halt or until the cycle budget is used up. Finally
//   it streams a register-file dump followed by a data-memory dump.
//
//   Optional build macro: DU_SINGLE_STEP_EN
//     When defined, each i_step pulse in RUN enables the pipeline for one cycle.
//     When undefined, i_step is ignored and the pipeline runs continuously.
//
// Ports
//   i_clk, i_reset            clock (rising edge), synchronous active-high reset
//   i_load_valid/_data/_last  program word stream in; o_load_ready accepts it
//   i_run, i_step             start pulse (LOADED only), single-step pulse
//   i_du_halt                 pipeline halt flag
//   i_du_regs_mem_data        register readback
//   i_du_mem_data             data-memory readback
//   o_du_data                 instruction word to the pipeline
//   o_du_inst_addr_wr         write / readback address
//   o_du_write_en             instruction-memory write strobe
//   o_du_read_en              pipeline run enable
//   o_dump_valid/_data/_last  dump stream out; i_dump_ready accepts it
//   o_state                   FSM state encoding
//   o_cycle_count             run cycles elapsed
//   o_timeout                 sticky flag: the run ended on budget, not on halt
module du_program_sequencer #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int IMEM_DEPTH      = 64,
  parameter int NUM_REGS        = 32,
  parameter int DMEM_DUMP_WORDS = 16,
  parameter int MAX_RUN_CYCLES  = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_du_halt,
  input  logic [DATA_W-1:0] i_du_regs_mem_data,
  input  logic [DATA_W-1:0] i_du_mem_data,
  output logic [DATA_W-1:0] o_du_data,
  output logic [ADDR_W-1:0] o_du_inst_addr_wr,
  output logic              o_du_write_en,
  output logic              o_du_read_en,
  output logic              o_dump_valid,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_last,
  input  logic              i_dump_ready,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_cycle_count,
  output logic              o_timeout
);

  localparam int CNT_W    = $clog2(IMEM_DEPTH + 1);
  localparam int DUMP_MAX = (NUM_REGS > DMEM_DUMP_WORDS) ? NUM_REGS : DMEM_DUMP_WORDS;
  localparam int IDX_W    = $clog2(DUMP_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_LOADED    = 3'd2,
    S_RUN       = 3'd3,
    S_DUMP_REGS = 3'd4,
    S_DUMP_MEM  = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  // Each dump index goes through three phases:
  //   PH_ADDR  - present the address,
  //   PH_CAPT  - capture the readback,
  //   PH_VALID - offer the captured word until it is accepted.
  typedef enum logic [1:0] {
    PH_ADDR  = 2'd0,
    PH_CAPT  = 2'd1,
    PH_VALID = 2'd2
  } phase_e;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] cycle_q, cycle_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  logic load_ready;
  logic run_en;
  logic dumping;
  logic dump_valid;
  logic last_reg;
  logic last_mem;

  assign load_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) &&
                      (word_cnt_q < CNT_W'(IMEM_DEPTH));

`ifdef DU_SINGLE_STEP_EN
  assign run_en = (state_q == S_RUN) && i_step;
`else
  logic unused_step;
  assign unused_step = i_step;
  assign run_en      = (state_q == S_RUN);
`endif

  assign dumping    = (state_q == S_DUMP_REGS) || (state_q == S_DUMP_MEM);
  assign dump_valid = dumping && (phase_q == PH_VALID);
  assign last_reg   = (idx_q == IDX_W'(NUM_REGS - 1));
  assign last_mem   = (idx_q == IDX_W'(DMEM_DUMP_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ADDR;
      word_cnt_q  <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      cycle_q     <= '0;
      timeout_q   <= 1'b0;
      idx_q       <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      word_cnt_q  <= word_cnt_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      cycle_q     <= cycle_d;
      timeout_q   <= timeout_d;
      idx_q       <= idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    word_cnt_d  = word_cnt_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    cycle_d     = cycle_q;
    timeout_d   = timeout_q;
    idx_d       = idx_q;
    dump_data_d = dump_data_q;

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (i_load_valid && load_ready) begin
          wr_en_d    = 1'b1;
          wdata_d    = i_load_data;
          addr_d     = ADDR_W'(word_cnt_q) << 2;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (i_load_last || (word_cnt_d == CNT_W'(IMEM_DEPTH))) state_d = S_LOADED;
          else                                                    state_d = S_LOAD;
        end
      end

      S_LOADED: begin
        if (i_run) begin
          state_d   = S_RUN;
          cycle_d   = '0;
          timeout_d = 1'b0;
        end
      end

      S_RUN: begin
        if (run_en) cycle_d = cycle_q + ADDR_W'(1);
        // Halt takes priority over the budget when both happen in the same cycle.
        if (i_du_halt || (run_en && (cycle_d == ADDR_W'(MAX_RUN_CYCLES)))) begin
          timeout_d = !i_du_halt;
          state_d   = S_DUMP_REGS;
          idx_d     = '0;
          phase_d   = PH_ADDR;
          addr_d    = '0;
        end
      end

      S_DUMP_REGS, S_DUMP_MEM: begin
        unique case (phase_q)
          PH_ADDR: phase_d = PH_CAPT;
          PH_CAPT: begin
            dump_data_d = (state_q == S_DUMP_REGS) ? i_du_regs_mem_data : i_du_mem_data;
            phase_d     = PH_VALID;
          end
          default: begin
            if (i_dump_ready) begin
              phase_d = PH_ADDR;
              if (state_q == S_DUMP_REGS) begin
                if (last_reg) begin
                  state_d = S_DUMP_MEM;
                  idx_d   = '0;
                  addr_d  = '0;
                end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  addr_d = ADDR_W'(idx_d);
                end
              end else begin
                if (last_mem) begin
                  state_d = S_DONE;
                end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  addr_d = ADDR_W'(idx_d) << 2;
                end
              end
            end
          end
        endcase
      end

      default: ;
    endcase
  end

  assign o_load_ready      = load_ready;
  assign o_du_data         = wdata_q;
  assign o_du_inst_addr_wr = addr_q;
  assign o_du_write_en     = wr_en_q;
  assign o_du_read_en      = run_en;
  assign o_dump_valid      = dump_valid;
  assign o_dump_data       = dump_data_q;
  assign o_dump_last       = dump_valid && (state_q == S_DUMP_MEM) && last_mem;
  assign o_state           = state_q;
  assign o_cycle_count     = cycle_q;
  assign o_timeout         = timeout_q;

endmodule

// File: tb/tb_du_program_sequencer.sv
// tb_du_program_sequencer
//   Directed testbench for du_program_sequencer. The DUT is built with
//   MAX_RUN_CYCLES=20. Register and memory readback come from a simple address
//   model: regs read 0xA0000000 | addr, and memory reads 0xB0000000 | addr.
module tb_du_program_sequencer;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        run;
  logic        step;
  logic        halt;
  logic [31:0] regs_data;
  logic [31:0] mem_data;
  logic [31:0] du_data;
  logic [31:0] du_addr;
  logic        du_wr;
  logic        du_rd;
  logic        dump_valid;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        dump_ready;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  du_program_sequencer #(
    .DATA_W         (32),
    .ADDR_W         (32),
    .IMEM_DEPTH     (64),
    .NUM_REGS       (32),
    .DMEM_DUMP_WORDS(16),
    .MAX_RUN_CYCLES (20)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_load_valid      (load_valid),
    .i_load_data       (load_data),
    .i_load_last       (load_last),
    .o_load_ready      (load_ready),
    .i_run             (run),
    .i_step            (step),
    .i_du_halt         (halt),
    .i_du_regs_mem_data(regs_data),
    .i_du_mem_data     (mem_data),
    .o_du_data         (du_data),
    .o_du_inst_addr_wr (du_addr),
    .o_du_write_en     (du_wr),
    .o_du_read_en      (du_rd),
    .o_dump_valid      (dump_valid),
    .o_dump_data       (dump_data),
    .o_dump_last       (dump_last),
    .i_dump_ready      (dump_ready),
    .o_state           (state),
    .o_cycle_count     (cycle_count),
    .o_timeout         (timeout)
  );

  assign regs_data = 32'hA000_0000 | du_addr;
  assign mem_data  = 32'hB000_0000 | du_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", load_ready); end
    n_cmp++; if ({du_wr, du_rd, dump_valid, dump_last, timeout} !== 5'b0) begin n_err++; $display("FAIL reset_strobes got %b want 00000", {du_wr, du_rd, dump_valid, dump_last, timeout}); end
    n_cmp++; if ({du_addr, du_data, cycle_count, dump_data} !== 128'b0) begin n_err++; $display("FAIL reset_buses got %h want 0", {du_addr, du_data, cycle_count, dump_data}); end
  endtask

  task automatic test_run_ignored();
    run = 1'b1;
    tick();
    run = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL run_in_idle_state got %0d want 0", state); end
    n_cmp++; if (du_rd !== 1'b0) begin n_err++; $display("FAIL run_in_idle_rd got %0b want 0", du_rd); end
  endtask

  task automatic test_load3();
    logic [31:0] words [3];
    words[0] = 32'h2443FFFF;
    words[1] = 32'hAC030007;
    words[2] = 32'hFC000000;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = words[k];
      load_last  = (k == 2);
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load3_ready[%0d] got %0b want 1", k, load_ready); end
      tick();
      n_cmp++; if (du_wr !== 1'b1) begin n_err++; $display("FAIL load3_wr[%0d] got %0b want 1", k, du_wr); end
      n_cmp++; if (du_addr !== 32'(4 * k)) begin n_err++; $display("FAIL load3_addr[%0d] got %0d want %0d", k, du_addr, 4 * k); end
      n_cmp++; if (du_data !== words[k]) begin n_err++; $display("FAIL load3_data[%0d] got %h want %h", k, du_data, words[k]); end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    n_cmp++; if (du_wr !== 1'b0) begin n_err++; $display("FAIL load3_wr_drop got %0b want 0", du_wr); end
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL load3_state got %0d want 2", state); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL load3_ready_after got %0b want 0", load_ready); end
  endtask

  task automatic test_run_halt();
    run = 1'b1;
    tick();
    run = 1'b0;
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL halt_run_state got %0d want 3", state); end
    n_cmp++; if (du_rd !== 1'b1) begin n_err++; $display("FAIL halt_run_rd got %0b want 1", du_rd); end
    repeat (11) tick();
    n_cmp++; if (cycle_count !== 32'd11) begin n_err++; $display("FAIL halt_count11 got %0d want 11", cycle_count); end
    n_cmp++; if (du_rd !== 1'b1) begin n_err++; $display("FAIL halt_rd_mid got %0b want 1", du_rd); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_cmp++; if (cycle_count !== 32'd12) begin n_err++; $display("FAIL halt_count got %0d want 12", cycle_count); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL halt_timeout got %0b want 0", timeout); end
    n_cmp++; if (du_rd !== 1'b0) begin n_err++; $display("FAIL halt_rd_drop got %0b want 0", du_rd); end
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL halt_state got %0d want 4", state); end
  endtask

  task automatic test_dump();
    int cnt = 0;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    for (int c = 0; c < 600 && state != 3'd6; c++) begin
      dump_ready = c[0];
      if (dump_valid && dump_ready) begin
        exp_addr = (cnt < 32) ? 32'(cnt) : 32'(4 * (cnt - 32));
        exp_data = ((cnt < 32) ? 32'hA000_0000 : 32'hB000_0000) | exp_addr;
        n_cmp++; if (dump_data !== exp_data) begin n_err++; $display("FAIL dump_data[%0d] got %h want %h", cnt, dump_data, exp_data); end
        n_cmp++; if (du_addr !== exp_addr) begin n_err++; $display("FAIL dump_addr[%0d] got %0d want %0d", cnt, du_addr, exp_addr); end
        n_cmp++; if (dump_last !== (cnt == 47)) begin n_err++; $display("FAIL dump_last[%0d] got %0b want %0b", cnt, dump_last, cnt == 47); end
        n_cmp++; if ({du_wr, du_rd} !== 2'b00) begin n_err++; $display("FAIL dump_strobes[%0d] got %b want 00", cnt, {du_wr, du_rd}); end
        cnt++;
      end
      tick();
    end
    dump_ready = 1'b0;
    n_cmp++; if (cnt !== 48) begin n_err++; $display("FAIL dump_count got %0d want 48", cnt); end
    n_cmp++; if (state !== 3'd6) begin n_err++; $display("FAIL dump_done_state got %0d want 6", state); end
    tick();
    n_cmp++; if ({dump_valid, du_wr, du_rd} !== 3'b000) begin n_err++; $display("FAIL done_strobes got %b want 000", {dump_valid, du_wr, du_rd}); end
    n_cmp++; if (cycle_count !== 32'd12 || timeout !== 1'b0) begin n_err++; $display("FAIL done_hold got count %0d timeout %0b want 12 0", cycle_count, timeout); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 65; k++) begin
      load_valid = 1'b1;
      load_data  = 32'h0000_1000 + 32'(k);
      load_last  = 1'b0;
      n_cmp++; if (load_ready !== (k < 64)) begin n_err++; $display("FAIL ovf_ready[%0d] got %0b want %0b", k, load_ready, k < 64); end
      tick();
      if (k < 64) begin
        n_cmp++; if (du_wr !== 1'b1 || du_addr !== 32'(4 * k) || du_data !== load_data) begin n_err++; $display("FAIL ovf_write[%0d] got wr %0b addr %0d data %h want 1 %0d %h", k, du_wr, du_addr, du_data, 4 * k, load_data); end
      end else begin
        n_cmp++; if (du_wr !== 1'b0) begin n_err++; $display("FAIL ovf_refused got %0b want 0", du_wr); end
      end
    end
    load_valid = 1'b0;
    n_cmp++; if (du_addr !== 32'd252) begin n_err++; $display("FAIL ovf_last_addr got %0d want 252", du_addr); end
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL ovf_state got %0d want 2", state); end
  endtask

  task automatic test_timeout();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (19) tick();
    n_cmp++; if (state !== 3'd3 || cycle_count !== 32'd19 || timeout !== 1'b0) begin n_err++; $display("FAIL tmo_pre got state %0d count %0d tmo %0b want 3 19 0", state, cycle_count, timeout); end
    tick();
    n_cmp++; if (cycle_count !== 32'd20) begin n_err++; $display("FAIL tmo_count got %0d want 20", cycle_count); end
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_flag got %0b want 1", timeout); end
    n_cmp++; if (state !== 3'd4 || du_rd !== 1'b0) begin n_err++; $display("FAIL tmo_exit got state %0d rd %0b want 4 0", state, du_rd); end
  endtask

  task automatic test_reset_mid_dump();
    dump_ready = 1'b1;
    for (int c = 0; c < 300 && state != 3'd5; c++) tick();
    n_cmp++; if (state !== 3'd5) begin n_err++; $display("FAIL mid_reach_mem got %0d want 5", state); end
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dump_ready = 1'b0;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL mid_reset_state got %0d want 0", state); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got %0b want 1", load_ready); end
    n_cmp++; if ({du_wr, du_rd, dump_valid, dump_last, timeout} !== 5'b0) begin n_err++; $display("FAIL mid_reset_strobes got %b want 00000", {du_wr, du_rd, dump_valid, dump_last, timeout}); end
    n_cmp++; if ({du_addr, du_data, cycle_count, dump_data} !== 128'b0) begin n_err++; $display("FAIL mid_reset_buses got %h want 0", {du_addr, du_data, cycle_count, dump_data}); end
  endtask

  task automatic test_halt_on_budget();
    do_reset();
    load_valid = 1'b1;
    load_data  = 32'hFC000000;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL hob_loaded got %0d want 2", state); end
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (19) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_cmp++; if (cycle_count !== 32'd20) begin n_err++; $display("FAIL hob_count got %0d want 20", cycle_count); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL hob_timeout got %0b want 0", timeout); end
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL hob_state got %0d want 4", state); end
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
    halt       = 1'b0;
    dump_ready = 1'b0;
    test_reset();
    test_run_ignored();
    test_load3();
    test_run_halt();
    test_dump();
    test_overflow();
    test_timeout();
    test_reset_mid_dump();
    test_halt_on_budget();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
